// File: rtl/unsigned_16by8_div_seq_pkg.sv
// Shared types, widths and the rounding helper for the 16-by-8 sequential divider.
// The optional round-to-nearest build is selected with UDIV_ROUND_EN.
package unsigned_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = 3;

    localparam logic [DIVISOR_W-1:0] QUO_SAT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Round half up, 2*rem >= divisor, never wrapping past saturation.
    function automatic logic [DIVISOR_W-1:0] round_quo(
        input logic [DIVISOR_W-1:0] quo,
        input logic [DIVISOR_W-1:0] rem,
        input logic [DIVISOR_W-1:0] dvs
    );
        logic [DIVISOR_W-1:0] res;
        if (({rem, 1'b0} >= {1'b0, dvs}) && (quo != QUO_SAT)) begin
            res = quo + 8'd1;
        end else begin
            res = quo;
        end
        return res;
    endfunction

endpackage

// File: rtl/unsigned_16by8_div_seq_if.sv
// Operand/result handshake bundle for the divider: slave side is the divider,
// master side is the requester that supplies operands and consumes results.
interface unsigned_16by8_div_seq_if;
    import unsigned_div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVISOR_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  ovf;
    logic                  dbz;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dbz
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/unsigned_16by8_div_seq_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to
// subtract the divisor, keep the difference only when it does not go negative.
module udiv_step
    import unsigned_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 q_bit
);
    logic [DIVISOR_W:0] shifted_s;

    assign shifted_s = {rem, dvd_bit};
    assign q_bit     = (shifted_s >= {1'b0, divisor});
    // rem < divisor on entry, so a successful difference always fits in 8 bits.
    assign rem_next  = q_bit ? 8'(shifted_s - {1'b0, divisor}) : shifted_s[DIVISOR_W-1:0];
endmodule

// File: rtl/unsigned_16by8_div_seq.sv
// Sequential radix-2 restoring 16/8 unsigned divider with valid/ready on both sides.
// Define UDIV_ROUND_EN to round the quotient to nearest (ties up, saturating).
module unsigned_16by8_div_seq
    import unsigned_div_pkg::*;
(
    input logic                     clk,
    input logic                     rst_n,
    unsigned_16by8_div_seq_if.slave div_if
);
    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [DIVISOR_W-1:0]   rem_r;
    logic [DIVISOR_W-1:0]   lo_r;
    logic [DIVISOR_W-2:0]   quo_r;
    logic [DIVISOR_W-1:0]   dvs_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [DIVISOR_W-1:0]   quotient_r;
    logic [DIVISOR_W-1:0]   remainder_r;
    logic                   ovf_r;
    logic                   dbz_r;

    logic [DIVISOR_W-1:0]   step_rem_s;
    logic                   step_q_s;
    logic [DIVISOR_W-1:0]   trunc_quo_s;
    logic [DIVISOR_W-1:0]   final_quo_s;

    udiv_step u_step (
        .rem      (rem_r),
        .dvd_bit  (lo_r[DIVISOR_W-1]),
        .divisor  (dvs_r),
        .rem_next (step_rem_s),
        .q_bit    (step_q_s)
    );

    assign trunc_quo_s = {quo_r, step_q_s};
`ifdef UDIV_ROUND_EN
    assign final_quo_s = round_quo(trunc_quo_s, step_rem_s, dvs_r);
`else
    assign final_quo_s = trunc_quo_s;
`endif

    // Control FSM, datapath shift registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            rem_r       <= 8'd0;
            lo_r        <= 8'd0;
            quo_r       <= 7'd0;
            dvs_r       <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= 8'd0;
            remainder_r <= 8'd0;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (div_if.in_valid) begin
                        dvs_r      <= div_if.divisor;
                        rem_r      <= div_if.dividend[15:8];
                        lo_r       <= div_if.dividend[7:0];
                        quo_r      <= 7'd0;
                        cnt_r      <= 3'd7;
                        in_ready_r <= 1'b0;
                        ovf_r      <= 1'b0;
                        dbz_r      <= 1'b0;
                        if (div_if.divisor == 8'd0) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            quotient_r  <= QUO_SAT;
                            remainder_r <= div_if.dividend[7:0];
                            dbz_r       <= 1'b1;
                        end else if (div_if.dividend[15:8] >= div_if.divisor) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            quotient_r  <= QUO_SAT;
                            remainder_r <= div_if.dividend[7:0];
                            ovf_r       <= 1'b1;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    rem_r <= step_rem_s;
                    lo_r  <= {lo_r[DIVISOR_W-2:0], 1'b0};
                    quo_r <= {quo_r[DIVISOR_W-3:0], step_q_s};
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r == 3'd0) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                        quotient_r  <= final_quo_s;
                        remainder_r <= step_rem_s;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    if (div_if.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign div_if.in_ready  = in_ready_r;
    assign div_if.out_valid = out_valid_r;
    assign div_if.quotient  = quotient_r;
    assign div_if.remainder = remainder_r;
    assign div_if.ovf       = ovf_r;
    assign div_if.dbz       = dbz_r;
endmodule
